// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - end-of-test monitor snooping per-hart register-file writes
// Optional watchdog and cycle counter built when TEST_MON_TIMEOUT_EN is defined.
module test_monitor #(
  parameter int NUM_HARTS      = 1,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int NUM_REG        = 3,
  parameter int DRAIN_CYCLES   = 5,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic [NUM_HARTS-1:0]    wb_we_i,
  input  logic [5*NUM_HARTS-1:0]  wb_waddr_i,
  input  logic [32*NUM_HARTS-1:0] wb_wdata_i,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic                    timeout_o,
  output logic [2:0]              fail_hart_o,
  output logic [31:0]             fail_testnum_o,
  output logic [31:0]             cycle_cnt_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_GRADED = 2'd2;

  logic [1:0]    state_q [NUM_HARTS];
  logic [1:0]    state_d [NUM_HARTS];
  logic [DW-1:0] drain_q [NUM_HARTS];
  logic [DW-1:0] drain_d [NUM_HARTS];
  logic [31:0]   num_q   [NUM_HARTS];
  logic [31:0]   num_d   [NUM_HARTS];
  logic [31:0]   done_q  [NUM_HARTS];
  logic [31:0]   done_d  [NUM_HARTS];
  logic [31:0]   pass_q  [NUM_HARTS];
  logic [31:0]   pass_d  [NUM_HARTS];
  logic [NUM_HARTS-1:0] hp_q, hp_d, wr;
  logic [4:0]    addr    [NUM_HARTS];
  logic [31:0]   data    [NUM_HARTS];

  logic        all_graded, all_pass, fail_any;
  logic [2:0]  fail_idx;
  logic [31:0] fail_num;

  always_ff @(posedge clk) begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (rst || clear_i) begin
        state_q[h] <= S_RUN;
        drain_q[h] <= '0;
        num_q[h]   <= '0;
        done_q[h]  <= '0;
        pass_q[h]  <= '0;
        hp_q[h]    <= 1'b0;
      end else begin
        state_q[h] <= state_d[h];
        drain_q[h] <= drain_d[h];
        num_q[h]   <= num_d[h];
        done_q[h]  <= done_d[h];
        pass_q[h]  <= pass_d[h];
        hp_q[h]    <= hp_d[h];
      end
    end
  end

  // Shadows see the write of the current edge, so grading uses the post-write pass value.
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      addr[h]    = wb_waddr_i[5*h +: 5];
      data[h]    = wb_wdata_i[32*h +: 32];
      wr[h]      = wb_we_i[h] && (addr[h] != 5'd0) && (state_q[h] != S_GRADED);
      num_d[h]   = (wr[h] && addr[h] == 5'(NUM_REG))  ? data[h] : num_q[h];
      done_d[h]  = (wr[h] && addr[h] == 5'(DONE_REG)) ? data[h] : done_q[h];
      pass_d[h]  = (wr[h] && addr[h] == 5'(PASS_REG)) ? data[h] : pass_q[h];
      state_d[h] = state_q[h];
      drain_d[h] = drain_q[h];
      hp_d[h]    = hp_q[h];
      case (state_q[h])
        S_RUN: begin
          if (wr[h] && addr[h] == 5'(DONE_REG) && done_d[h] == 32'h1) begin
            state_d[h] = S_DRAIN;
            drain_d[h] = '0;
          end
        end
        S_DRAIN: begin
          drain_d[h] = drain_q[h] + 1'b1;
          if (drain_q[h] == DW'(DRAIN_CYCLES - 1)) begin
            state_d[h] = S_GRADED;
            hp_d[h]    = (pass_d[h] == 32'h1);
          end
        end
        default: ;
      endcase
    end
  end

  // Descending scan leaves the lowest-index failing hart as the final winner.
  always_comb begin
    all_graded = 1'b1;
    all_pass   = 1'b1;
    fail_any   = 1'b0;
    fail_idx   = '0;
    fail_num   = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (state_q[h] != S_GRADED) all_graded = 1'b0;
      if (!hp_q[h]) all_pass = 1'b0;
      if (state_q[h] == S_GRADED && !hp_q[h]) begin
        fail_any = 1'b1;
        fail_idx = 3'(h);
        fail_num = num_q[h];
      end
    end
  end

`ifdef TEST_MON_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout_q;
  logic        all_graded_d;

  always_comb begin
    all_graded_d = 1'b1;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (state_d[h] != S_GRADED) all_graded_d = 1'b0;
    end
    wd_d = (wd_q == 32'hFFFF_FFFF) ? wd_q : wd_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (!done_o) begin
      wd_q <= wd_d;
      if (wd_d >= 32'(TIMEOUT_CYCLES) && !all_graded_d) timeout_q <= 1'b1;
    end
  end

  assign timeout_o   = timeout_q;
  assign cycle_cnt_o = wd_q;
`else
  assign timeout_o   = 1'b0;
  assign cycle_cnt_o = '0;
`endif

  assign done_o         = all_graded | timeout_o;
  assign pass_o         = all_graded & all_pass & ~timeout_o;
  assign fail_o         = fail_any;
  assign fail_hart_o    = fail_idx;
  assign fail_testnum_o = fail_num;

endmodule

// File: tb/tb_test_monitor.sv
// tb/tb_test_monitor.sv - directed and random checks of test_monitor against an edge-indexed model
module tb_test_monitor;

  localparam int NH    = 2;
  localparam int DRAIN = 5;
  localparam int TMO   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic [1:0]  wb_we_i = '0;
  logic [9:0]  wb_waddr_i = '0;
  logic [63:0] wb_wdata_i = '0;
  logic        done_o, pass_o, fail_o, timeout_o;
  logic [2:0]  fail_hart_o;
  logic [31:0] fail_testnum_o, cycle_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  test_monitor #(
    .NUM_HARTS(NH), .DONE_REG(26), .PASS_REG(27), .NUM_REG(3),
    .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .fail_hart_o(fail_hart_o), .fail_testnum_o(fail_testnum_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  // Model: each hart remembers the edge index of its done write; it is graded DRAIN edges later.
  int          e;
  logic [31:0] m_num  [NH];
  logic [31:0] m_pass [NH];
  int          m_done_e [NH];
  bit          m_gr [NH];
  bit          m_hp [NH];
  bit          m_to;
  int          m_cyc;

  function automatic bit m_all_gr();
    bit r = 1'b1;
    for (int h = 0; h < NH; h++) if (!m_gr[h]) r = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    e = 0; m_to = 1'b0; m_cyc = 0;
    for (int h = 0; h < NH; h++) begin
      m_num[h] = '0; m_pass[h] = '0; m_done_e[h] = -1; m_gr[h] = 1'b0; m_hp[h] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [1:0] we, input logic [4:0] a [NH], input logic [31:0] d [NH]);
    bit prev_done = m_all_gr() || m_to;
    e++;
    for (int h = 0; h < NH; h++) begin
      if (!m_gr[h] && we[h] && a[h] != 5'd0) begin
        if (a[h] == 5'd3)  m_num[h]  = d[h];
        if (a[h] == 5'd27) m_pass[h] = d[h];
        if (a[h] == 5'd26 && d[h] == 32'h1 && m_done_e[h] < 0) m_done_e[h] = e;
      end
      if (!m_gr[h] && m_done_e[h] >= 0 && e == m_done_e[h] + DRAIN) begin
        m_gr[h] = 1'b1;
        m_hp[h] = (m_pass[h] == 32'h1);
      end
    end
`ifdef TEST_MON_TIMEOUT_EN
    if (!prev_done) begin
      m_cyc++;
      if (!m_all_gr() && m_cyc >= TMO) m_to = 1'b1;
    end
`else
    if (prev_done) m_cyc = 0;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic check_all();
    bit ag = m_all_gr();
    bit ap = 1'b1;
    bit fl = 1'b0;
    int fh = 0;
    for (int h = 0; h < NH; h++) if (!m_hp[h]) ap = 1'b0;
    for (int h = NH - 1; h >= 0; h--) if (m_gr[h] && !m_hp[h]) begin fl = 1'b1; fh = h; end
    chk("done",    32'(done_o),      32'(ag || m_to));
    chk("pass",    32'(pass_o),      32'(ag && ap && !m_to));
    chk("fail",    32'(fail_o),      32'(fl));
    chk("timeout", 32'(timeout_o),   32'(m_to));
    chk("fhart",   32'(fail_hart_o), fl ? 32'(fh) : 32'd0);
    chk("fnum",    fail_testnum_o,   fl ? m_num[fh] : 32'd0);
    chk("cycles",  cycle_cnt_o,      32'(m_cyc));
  endtask

  task automatic cyc(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1);
    logic [4:0]  a [NH];
    logic [31:0] d [NH];
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    wb_we_i = we; wb_waddr_i = {a1, a0}; wb_wdata_i = {d1, d0};
    @(posedge clk);
    model_step(we, a, d);
    #1;
    check_all();
    wb_we_i = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic do_reset(input bit use_clear);
    wb_we_i = '0;
    if (use_clear) clear_i = 1'b1; else rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst = 1'b0; clear_i = 1'b0;
  endtask

  initial begin
    logic [4:0]  regs [5];
    logic [31:0] vals [4];
    model_reset();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;

    // Both harts: x3=7, x27=1, then x26=1 -> pass after DRAIN edges
    cyc(2'b11, 5'd3, 32'd7, 5'd3, 32'd7);
    cyc(2'b11, 5'd27, 32'd1, 5'd27, 32'd1);
    cyc(2'b11, 5'd26, 32'd1, 5'd26, 32'd1);
    idle(4);
    chk("t1_not_yet", 32'(done_o), 32'd0);
    idle(1);
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_pass", 32'(pass_o), 32'd1);
    chk("t1_fail", 32'(fail_o), 32'd0);

    // Hart0 fails with test 12; a late pass write is ignored
    do_reset(1'b0);
    cyc(2'b11, 5'd27, 32'd0, 5'd27, 32'd1);
    cyc(2'b11, 5'd3, 32'd12, 5'd3, 32'd9);
    cyc(2'b11, 5'd26, 32'd1, 5'd26, 32'd1);
    idle(5);
    cyc(2'b01, 5'd27, 32'd1, 5'd0, 32'd0);
    chk("t2_fail", 32'(fail_o), 32'd1);
    chk("t2_fnum", fail_testnum_o, 32'd12);
    chk("t2_pass", 32'(pass_o), 32'd0);

    // x26=2 starts nothing; pass written on the last drain edge still counts
    do_reset(1'b1);
    cyc(2'b11, 5'd26, 32'd2, 5'd27, 32'd1);
    idle(7);
    chk("t3_nodrain", 32'(done_o), 32'd0);
    cyc(2'b11, 5'd26, 32'd1, 5'd26, 32'd1);
    idle(4);
    cyc(2'b01, 5'd27, 32'd1, 5'd0, 32'd0);
    chk("t3_pass", 32'(pass_o), 32'd1);

    // Hart1 fails first (x3=4); hart0 passes later
    do_reset(1'b0);
    cyc(2'b11, 5'd27, 32'd1, 5'd3, 32'd4);
    cyc(2'b10, 5'd0, 32'd0, 5'd26, 32'd1);
    idle(5);
    chk("t4_fail", 32'(fail_o), 32'd1);
    chk("t4_fhart", 32'(fail_hart_o), 32'd1);
    chk("t4_fnum", fail_testnum_o, 32'd4);
    chk("t4_notdone", 32'(done_o), 32'd0);
    cyc(2'b01, 5'd26, 32'd1, 5'd0, 32'd0);
    idle(5);
    chk("t4_done", 32'(done_o), 32'd1);
    chk("t4_pass", 32'(pass_o), 32'd0);

    // Watchdog: nothing finishes
    do_reset(1'b0);
    idle(TMO);
    idle(5);
`ifdef TEST_MON_TIMEOUT_EN
    chk("t5_timeout", 32'(timeout_o), 32'd1);
    chk("t5_cycles", cycle_cnt_o, 32'd100);
`else
    chk("t5_timeout", 32'(timeout_o), 32'd0);
    chk("t5_done", 32'(done_o), 32'd0);
`endif

    // Grading on the watchdog edge wins
    do_reset(1'b0);
    cyc(2'b11, 5'd27, 32'd1, 5'd27, 32'd1);
    idle(TMO - DRAIN - 2);
    cyc(2'b11, 5'd26, 32'd1, 5'd26, 32'd1);
    idle(DRAIN);
    chk("t5b_timeout", 32'(timeout_o), 32'd0);
    chk("t5b_pass", 32'(pass_o), 32'd1);

    // Clear mid-drain, then a normal run
    do_reset(1'b0);
    cyc(2'b11, 5'd26, 32'd1, 5'd26, 32'd1);
    idle(2);
    do_reset(1'b1);
    chk("t6_cleared", {29'd0, done_o, fail_o, pass_o}, 32'd0);
    cyc(2'b11, 5'd27, 32'd1, 5'd27, 32'd1);
    cyc(2'b11, 5'd26, 32'd1, 5'd26, 32'd1);
    idle(5);
    chk("t6_pass", 32'(pass_o), 32'd1);

    // Random write traffic
    regs[0] = 5'd0; regs[1] = 5'd3; regs[2] = 5'd26; regs[3] = 5'd27; regs[4] = 5'd0;
    vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'd2; vals[3] = 32'd0;
    for (int r = 0; r < 12; r++) begin
      int len;
      do_reset(r[0]);
      len = $urandom_range(10, 80);
      for (int c = 0; c < len; c++) begin
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        regs[4] = 5'($urandom);
        vals[3] = $urandom;
        a0 = regs[$urandom_range(0, 4)]; a1 = regs[$urandom_range(0, 4)];
        d0 = vals[$urandom_range(0, 3)]; d1 = vals[$urandom_range(0, 3)];
        cyc(2'($urandom), a0, d0, a1, d1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/test_monitor.md
# test_monitor

Synthesizable end-of-test monitor for multi-hart tinyriscv simulation and FPGA self-test. It snoops each hart's register-file write port and shadows the test-number, done and pass registers. It drains a fixed number of cycles after a hart signals done, then grades pass/fail per hart and aggregates the result. A watchdog flags runs that never finish. The block sits beside the core(s) in the SoC top and needs no hierarchical references into the register file.

## Interface
- NUM_HARTS, 1, number of monitored write ports (1..8)
- DONE_REG, 26, register index whose write of 1 ends the test
- PASS_REG, 27, register index holding 1 on pass
- NUM_REG, 3, register index holding the current test number
- DRAIN_CYCLES, 5, cycles between done and grading (>=1)
- TIMEOUT_CYCLES, 50000, watchdog limit in clk cycles (>=2)

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous soft restart, same effect as rst; rst has priority
- wb_we_i  in  NUM_HARTS  register write enable per hart
- wb_waddr_i  in  5*NUM_HARTS  write index, hart h at [5h+4:5h]
- wb_wdata_i  in  32*NUM_HARTS  write data, hart h at [32h+31:32h]
- done_o  out  1  all harts graded, or timeout
- pass_o  out  1  all harts graded and all passed, no timeout
- fail_o  out  1  at least one graded hart failed
- timeout_o  out  1  watchdog expired before all harts graded
- fail_hart_o  out  3  lowest-index failing hart
- fail_testnum_o  out  32  NUM_REG shadow of fail_hart_o
- cycle_cnt_o  out  32  cycles since reset, frozen at done_o

## Operation
- Per hart, three 32-bit shadows (num, done, pass) update on any edge with we=1 and waddr matching the index. Writes to x0 are ignored.
- Per-hart FSM with states RUN, DRAIN and GRADED.
  - RUN -> DRAIN on a write of exactly 32'h1 to DONE_REG. The drain counter clears to 0. Other values update the shadow only.
  - DRAIN: shadows keep updating. The counter increments each edge. When the counter reaches DRAIN_CYCLES-1, the FSM moves to GRADED and latches hart_pass = (pass shadow after this edge's write == 32'h1).
  - GRADED: shadows and hart_pass are frozen, and writes are ignored.
- all_graded = every hart is GRADED. done_o = all_graded | timeout_o. pass_o = all_graded & all hart_pass & ~timeout_o.
- fail_o = OR over GRADED harts with hart_pass=0. It can assert before done_o.
- fail_hart_o/fail_testnum_o report the lowest-index failing GRADED hart. Both are 0 when fail_o=0.
- The watchdog counter increments each edge while done_o=0 and saturates. timeout_o sets at the edge where the count reaches TIMEOUT_CYCLES with all_graded still 0 after that edge.
  - If the last hart grades on that same edge, grading wins and timeout_o stays 0.
- rst or clear_i returns all FSMs to RUN and zeroes all shadows, counters and outputs, including mid-drain.

## Timing
- Every output resets to 0.
- All outputs decode combinationally from registers, so they are valid right after the edge that changes state.
- A done write sampled at edge N makes the hart GRADED after edge N+DRAIN_CYCLES. done_o follows at the same edge when it is the last hart.
- A PASS_REG write sampled at edge N+DRAIN_CYCLES still counts. A write after that edge does not.
- cycle_cnt_o = number of edges since reset release, held from the edge where done_o rises.
- Harts are independent. Simultaneous done writes on several harts grade on the same edge.

## Configuration
- TEST_MON_TIMEOUT_EN defined: the watchdog and cycle counter are built as described.
- TEST_MON_TIMEOUT_EN undefined: no counter logic is built. timeout_o and cycle_cnt_o are tied to 0, and done_o = all_graded.

## Test plan
- NUM_HARTS=1: write x3=7, x27=1, then x26=1 at edge N -> done_o=1 and pass_o=1 after edge N+5; fail_o=0.
- NUM_HARTS=1: write x27=0, x3=12, x26=1 -> after 5 cycles done_o=1, fail_o=1, fail_testnum_o=12; x27=1 written at edge N+6 does not change the result.
- Write x27=1 at edge N+5 (the last drain edge) after x26=1 at N -> pass_o=1. Write x26=2 -> no drain starts.
- NUM_HARTS=2: hart1 fails (x3=4) and hart0 passes later -> fail_o rises at hart1's grading edge with fail_hart_o=1; done_o only after hart0 grades, with pass_o=0.
- TIMEOUT_CYCLES=100, no done write -> timeout_o=done_o=1 after edge 100, pass_o=0, cycle_cnt_o=100 held. Last hart grading exactly at edge 100 -> timeout_o=0.
- Assert clear_i mid-DRAIN -> all outputs 0 next edge; a subsequent test grades normally.
